// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, load-unit state encoding and load decode helpers
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_LBU = 6'd36;
  localparam logic [5:0] OP_LHU = 6'd37;
  localparam logic [5:0] OP_SB  = 6'd40;
  localparam logic [5:0] OP_SH  = 6'd41;
  localparam logic [5:0] OP_SW  = 6'd43;

  localparam logic [1:0] LU_IDLE = 2'd0;
  localparam logic [1:0] LU_BUSY = 2'd1;
  localparam logic [1:0] LU_DONE = 2'd2;

  // True for the five opcodes this unit serves; stores and everything else are ignored.
  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Halfword loads need an even address, word loads a word-aligned one; bytes are always fine.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if ((op == OP_LH) || (op == OP_LHU)) bad = lo[0];
    if (op == OP_LW)                     bad = (lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - byte/half/word lane extraction with sign or zero extension
module load_ext
  import mips_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half out of the word, then extend according to the opcode.
  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
    data = 32'd0;
    case (op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'd0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'd0, half_sel};
      OP_LW:   data = word;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - MEM-stage load unit: word read over req/ack, pipeline stall, extended result
module load_unit
  import mips_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        adel,
  output logic        bus_err
);

  logic [1:0]  state;
  logic [5:0]  op_q;
  logic [1:0]  lane_q;
  logic [7:0]  wait_cnt;
  logic [31:0] ext_data;
  logic        load_op;
  logic        misaligned;
  logic        accept;
  logic        timeout_hit;

  // Decode the incoming instruction; only an aligned load seen in IDLE starts a read.
  always_comb begin
    load_op     = is_load(op);
    misaligned  = is_misaligned(op, addr[1:0]);
    accept      = (state == LU_IDLE) && start && load_op && !misaligned;
    timeout_hit = (wait_cnt == (TIMEOUT - 8'd1));
  end

  // Stall must rise in the accepting cycle itself and vanish the moment reset is asserted.
  assign stall = reset && (accept || (state == LU_BUSY));

  load_ext u_ext (
    .op   (op_q),
    .lane (lane_q),
    .word (mem_rdata),
    .data (ext_data)
  );

  // Request FSM with timeout counter; all outputs except stall are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LU_IDLE;
      op_q     <= 6'd0;
      lane_q   <= 2'd0;
      wait_cnt <= 8'd0;
      mem_req  <= 1'b0;
      mem_addr <= 32'd0;
      ld_valid <= 1'b0;
      ld_data  <= 32'd0;
      adel     <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      adel     <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        LU_IDLE: begin
          if (accept) begin
            op_q     <= op;
            lane_q   <= addr[1:0];
            mem_addr <= {addr[31:2], 2'b00};
            mem_req  <= 1'b1;
            wait_cnt <= 8'd0;
            state    <= LU_BUSY;
          end else if (start && load_op && misaligned) begin
            adel <= 1'b1;
          end
        end
        LU_BUSY: begin
          // An ack arriving on the timeout cycle still completes the load.
          if (mem_ack) begin
            ld_data  <= ext_data;
            ld_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= LU_DONE;
          end else if (timeout_hit) begin
            bus_err  <= 1'b1;
            mem_req  <= 1'b0;
            wait_cnt <= 8'd0;
            state    <= LU_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        LU_DONE: begin
          // The completed load is still sitting in MEM this cycle, so start is not re-examined.
          wait_cnt <= 8'd0;
          state    <= LU_IDLE;
        end
        default: state <= LU_IDLE;
      endcase
    end
  end

endmodule
